// File: rtl/ceespu_fetch.sv
// Instruction fetch stage of the ceespu.
// Issues word fetches to the arbitrated instruction memory port, buffers the
// returned words in a 2-entry FIFO, and presents one instruction per cycle to
// decode. A redirect flushes everything and restarts fetch at the target.
//
// Ports:
//   I_clk, I_rst_n        clock, async active-low reset
//   I_stall               decode stalled: output register holds
//   I_branch/Target       redirect request and word target address
//   O_imem_req/addr       fetch request and word address (combinational)
//   I_imem_gnt            request accepted at this edge
//   I_imem_data           response word, valid the cycle after the grant edge
//   O_instruction/O_PC    instruction and its word address for decode
//   O_valid               1 = real instruction, 0 = bubble
//   O_justBranched        first valid instruction after a redirect
module ceespu_fetch #(
    parameter logic [24:0] RESET_PC = 25'd0,
    parameter logic [31:0] NOP_INSN = 32'h0
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_stall,
    input  logic        I_branch,
    input  logic [24:0] I_branchTarget,
    output logic        O_imem_req,
    output logic [24:0] O_imem_addr,
    input  logic        I_imem_gnt,
    input  logic [31:0] I_imem_data,
    output logic [31:0] O_instruction,
    output logic [24:0] O_PC,
    output logic        O_valid,
    output logic        O_justBranched
);

    localparam int unsigned AW    = 25;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] fins_q [DEPTH];
    logic [DW-1:0] fins_d [DEPTH];
    logic [AW-1:0] fpc_q  [DEPTH];
    logic [AW-1:0] fpc_d  [DEPTH];
    logic [1:0]    count_q, count_d;
    logic          inflight_q, inflight_d;
    logic          kill_q, kill_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] insn_q, insn_d;
    logic [AW-1:0] opc_q, opc_d;
    logic          valid_q, valid_d;
    logic          jb_q, jb_d;
    logic          jbp_q, jbp_d;

    logic          xfer;
    logic          resp_live;
    logic          pop, push, bypass;
    logic [1:0]    level;

    // Request only when every outstanding word is guaranteed a FIFO slot.
    assign O_imem_req  = I_rst_n && !I_branch &&
                         ((3'(count_q) + 3'(inflight_q)) < 3'(DEPTH));
    assign O_imem_addr = pc_q;
    assign xfer        = O_imem_req && I_imem_gnt;
    assign resp_live   = inflight_q && !kill_q;

    assign O_instruction  = insn_q;
    assign O_PC           = opc_q;
    assign O_valid        = valid_q;
    assign O_justBranched = jb_q;

    // Next-state: fetch pointer, FIFO (head always in slot 0), output register.
    always_comb begin
        pc_d       = pc_q;
        fins_d     = fins_q;
        fpc_d      = fpc_q;
        count_d    = count_q;
        inflight_d = xfer;
        kill_d     = 1'b0;
        tag_d      = tag_q;
        insn_d     = insn_q;
        opc_d      = opc_q;
        valid_d    = valid_q;
        jb_d       = jb_q;
        jbp_d      = jbp_q;
        pop        = 1'b0;
        push       = 1'b0;
        bypass     = 1'b0;
        level      = count_q;

        if (xfer) begin
            pc_d  = pc_q + AW'(1);
            tag_d = pc_q;
        end

        if (I_branch) begin
            pc_d       = I_branchTarget;
            count_d    = 2'd0;
            kill_d     = inflight_q;
            inflight_d = 1'b0;
            insn_d     = NOP_INSN;
            valid_d    = 1'b0;
            jb_d       = 1'b0;
            jbp_d      = 1'b1;
        end else begin
            if (!I_stall) begin
                if (count_q != 2'd0) begin
                    insn_d  = fins_q[0];
                    opc_d   = fpc_q[0];
                    valid_d = 1'b1;
                    jb_d    = jbp_q;
                    jbp_d   = 1'b0;
                    pop     = 1'b1;
                end else if (resp_live) begin
                    insn_d  = I_imem_data;
                    opc_d   = tag_q;
                    valid_d = 1'b1;
                    jb_d    = jbp_q;
                    jbp_d   = 1'b0;
                    bypass  = 1'b1;
                end else begin
                    insn_d  = NOP_INSN;
                    valid_d = 1'b0;
                    jb_d    = 1'b0;
                end
            end

            push = resp_live && !bypass;

            // Shift on pop, then append behind whatever remains.
            if (pop) begin
                fins_d[0] = fins_q[1];
                fpc_d[0]  = fpc_q[1];
            end
            level = count_q - 2'(pop);
            if (push) begin
                if (level == 2'd0) begin
                    fins_d[0] = I_imem_data;
                    fpc_d[0]  = tag_q;
                end else begin
                    fins_d[1] = I_imem_data;
                    fpc_d[1]  = tag_q;
                end
            end
            count_d = level + 2'(push);
        end
    end

    // State registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pc_q       <= RESET_PC;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fins_q[i] <= '0;
                fpc_q[i]  <= '0;
            end
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            tag_q      <= '0;
            insn_q     <= NOP_INSN;
            opc_q      <= RESET_PC;
            valid_q    <= 1'b0;
            jb_q       <= 1'b0;
            jbp_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            fins_q     <= fins_d;
            fpc_q      <= fpc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            tag_q      <= tag_d;
            insn_q     <= insn_d;
            opc_q      <= opc_d;
            valid_q    <= valid_d;
            jb_q       <= jb_d;
            jbp_q      <= jbp_d;
        end
    end

endmodule

// File: tb/tb_ceespu_fetch.sv
// Bench for ceespu_fetch: a memory responder, an instruction-stream model
// (expected next PC, redirect flag, hold/bubble rules) checked every cycle,
// and directed scenarios with literal expectations.
module tb_ceespu_fetch;

    localparam logic [24:0] RST_PC = 25'd0;
    localparam logic [31:0] NOP    = 32'h0;

    logic        I_clk;
    logic        I_rst_n;
    logic        I_stall;
    logic        I_branch;
    logic [24:0] I_branchTarget;
    logic        O_imem_req;
    logic [24:0] O_imem_addr;
    logic        I_imem_gnt;
    logic [31:0] I_imem_data;
    logic [31:0] O_instruction;
    logic [24:0] O_PC;
    logic        O_valid;
    logic        O_justBranched;

    ceespu_fetch #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
        .I_clk(I_clk),
        .I_rst_n(I_rst_n),
        .I_stall(I_stall),
        .I_branch(I_branch),
        .I_branchTarget(I_branchTarget),
        .O_imem_req(O_imem_req),
        .O_imem_addr(O_imem_addr),
        .I_imem_gnt(I_imem_gnt),
        .I_imem_data(I_imem_data),
        .O_instruction(O_instruction),
        .O_PC(O_PC),
        .O_valid(O_valid),
        .O_justBranched(O_justBranched)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [24:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    // Memory: word valid the cycle after a granting edge, junk otherwise.
    initial I_imem_data = 32'h0;
    always @(posedge I_clk) begin
        if (O_imem_req && I_imem_gnt) I_imem_data <= mem_word(O_imem_addr);
        else                          I_imem_data <= $urandom;
    end

    // Inputs as seen by the DUT at the most recent rising edge.
    logic        s_rst    = 1'b0;
    logic        s_stall  = 1'b0;
    logic        s_branch = 1'b0;
    logic        s_gnt    = 1'b0;
    logic [24:0] s_tgt    = '0;
    always @(posedge I_clk) begin
        s_rst    <= I_rst_n;
        s_stall  <= I_stall;
        s_branch <= I_branch;
        s_gnt    <= I_imem_gnt;
        s_tgt    <= I_branchTarget;
    end

    // Stream model: valid words appear in fetch order starting at the last
    // redirect/reset address; stalls hold; bubbles keep the PC.
    logic [24:0] exp_pc     = RST_PC;
    logic        jb_exp     = 1'b0;
    int          run        = 0;
    logic [31:0] prev_insn  = NOP;
    logic [24:0] prev_pc    = RST_PC;
    logic        prev_valid = 1'b0;
    logic        prev_jb    = 1'b0;

    always @(negedge I_clk) begin
        if (!I_rst_n || !s_rst) begin
            chk("rst_valid", 32'(O_valid), 32'd0);
            chk("rst_pc",    32'(O_PC), 32'(RST_PC));
            chk("rst_insn",  O_instruction, NOP);
            chk("rst_jb",    32'(O_justBranched), 32'd0);
            exp_pc = RST_PC;
            jb_exp = 1'b0;
            run    = 0;
        end else if (s_branch) begin
            chk("redir_valid", 32'(O_valid), 32'd0);
            chk("redir_insn",  O_instruction, NOP);
            chk("redir_jb",    32'(O_justBranched), 32'd0);
            chk("redir_pc",    32'(O_PC), 32'(prev_pc));
            exp_pc = s_tgt;
            jb_exp = 1'b1;
            run    = 0;
        end else begin
            run = s_gnt ? run + 1 : 0;
            if (s_stall) begin
                chk("hold_insn",  O_instruction, prev_insn);
                chk("hold_pc",    32'(O_PC), 32'(prev_pc));
                chk("hold_valid", 32'(O_valid), 32'(prev_valid));
                chk("hold_jb",    32'(O_justBranched), 32'(prev_jb));
            end else begin
                if (run >= 3) chk("live_valid", 32'(O_valid), 32'd1);
                if (O_valid) begin
                    chk("seq_pc",   32'(O_PC), 32'(exp_pc));
                    chk("seq_insn", O_instruction, mem_word(exp_pc));
                    chk("seq_jb",   32'(O_justBranched), 32'(jb_exp));
                    exp_pc = exp_pc + 25'd1;
                    jb_exp = 1'b0;
                end else begin
                    chk("bub_insn", O_instruction, NOP);
                    chk("bub_jb",   32'(O_justBranched), 32'd0);
                    chk("bub_pc",   32'(O_PC), 32'(prev_pc));
                end
            end
        end
        prev_insn  = O_instruction;
        prev_pc    = O_PC;
        prev_valid = O_valid;
        prev_jb    = O_justBranched;
    end

    initial begin
        I_rst_n        = 1'b0;
        I_stall        = 1'b0;
        I_branch       = 1'b0;
        I_branchTarget = '0;
        I_imem_gnt     = 1'b1;
        repeat (3) tick();
        chk("req_in_reset", 32'(O_imem_req), 32'd0);
        I_rst_n = 1'b1;

        // Startup: first grant at edge 1, first valid word at edge 2.
        tick();
        chk("e1_valid", 32'(O_valid), 32'd0);
        chk("e1_req",   32'(O_imem_req), 32'd1);
        chk("e1_addr",  32'(O_imem_addr), 32'd1);
        tick();
        chk("e2_valid", 32'(O_valid), 32'd1);
        chk("e2_pc",    32'(O_PC), 32'd0);
        chk("e2_insn",  O_instruction, 32'hA000_0000);
        repeat (5) tick();
        chk("e7_pc", 32'(O_PC), 32'd5);

        // Three stalled edges: output frozen, FIFO fills, request drops.
        I_stall = 1'b1;
        repeat (3) tick();
        chk("stall_pc",  32'(O_PC), 32'd5);
        chk("stall_req", 32'(O_imem_req), 32'd0);
        I_stall = 1'b0;
        tick(); chk("unstall_pc6", 32'(O_PC), 32'd6);
        tick(); chk("unstall_pc7", 32'(O_PC), 32'd7);
        tick(); chk("unstall_pc8", 32'(O_PC), 32'd8);

        // Redirect while word 9 is in flight.
        I_branch       = 1'b1;
        I_branchTarget = 25'h100;
        tick();
        chk("br_valid", 32'(O_valid), 32'd0);
        I_branch = 1'b0;
        tick();
        chk("br_bubble2", 32'(O_valid), 32'd0);
        chk("br_addr",    32'(O_imem_addr), 32'h101);
        tick();
        chk("br_pc",  32'(O_PC), 32'h100);
        chk("br_jb",  32'(O_justBranched), 32'd1);
        chk("br_ins", O_instruction, 32'hA000_0100);
        tick();
        chk("br_pc2", 32'(O_PC), 32'h101);
        chk("br_jb2", 32'(O_justBranched), 32'd0);

        // Grant toggling with a stall window.
        for (int i = 0; i < 24; i++) begin
            I_imem_gnt = (i % 2) == 0;
            I_stall    = (i >= 8 && i < 12);
            tick();
        end

        // Redirect and stall on the same edge: redirect wins.
        I_imem_gnt     = 1'b1;
        I_stall        = 1'b1;
        I_branch       = 1'b1;
        I_branchTarget = 25'h200;
        tick();
        chk("bs_valid", 32'(O_valid), 32'd0);
        chk("bs_insn",  O_instruction, NOP);
        I_stall  = 1'b0;
        I_branch = 1'b0;
        tick();
        tick();
        chk("bs_pc", 32'(O_PC), 32'h200);
        chk("bs_jb", 32'(O_justBranched), 32'd1);

        // Fetch pointer wraps from the top word to zero.
        I_branch       = 1'b1;
        I_branchTarget = 25'h1FF_FFFF;
        tick();
        I_branch = 1'b0;
        tick();
        tick();
        chk("wrap_top", 32'(O_PC), 32'h1FF_FFFF);
        tick();
        chk("wrap_zero",  32'(O_PC), 32'd0);
        chk("wrap_insn",  O_instruction, 32'hA000_0000);

        // Asynchronous reset mid-stream.
        repeat (3) tick();
        I_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(O_valid), 32'd0);
        chk("arst_pc",    32'(O_PC), 32'(RST_PC));
        chk("arst_insn",  O_instruction, NOP);
        chk("arst_req",   32'(O_imem_req), 32'd0);
        tick();
        I_rst_n = 1'b1;
        repeat (6) tick();
        chk("restart_pc", 32'(O_PC), 32'd4);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
